// File: rtl/mem_bank_responder.sv
// mem_bank_responder: bank-side responder for CPU loads/stores.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module mem_bank_responder #(
  parameter int PADDR_W  = 13,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               mRead,
  input  logic               mWrite,
  input  logic [1:0]         mSize,
  input  logic               mSignExt,
  input  logic [PADDR_W-1:0] pAddr,
  input  logic [2:0]         mEnab,
  input  logic [1:0]         mBank,
  input  logic               iAddr,
  input  logic [31:0]        wData,
  output logic               ready,
  output logic [31:0]        rData,
  output logic               rValid,
  output logic               wDone,
  output logic               error,
  output logic [PADDR_W-3:0] memAddr,
  output logic [31:0]        memWData,
  output logic [2:0]         memRe,
  output logic [2:0]         memWe,
  input  logic [31:0]        bankRData0,
  input  logic [31:0]        bankRData1,
  input  logic [31:0]        bankRData2
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERR,
    S_RD,
    S_WAIT,
    S_RESP,
    S_WR,
    S_RMW_RD,
    S_RMW_WAIT,
    S_RMW_WR
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(READ_LAT - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  l_size;
  logic        l_sext;
  logic [1:0]  l_off;
  logic [1:0]  l_bank;
  logic [2:0]  l_enab;
  logic [31:0] l_wdata;
  logic [31:0] bank_word;
  logic        bad;
  logic        one_hot;

  // Extract the addressed byte/half and extend it to 32 bits.
  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic        sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the old word with store data.
  function automatic logic [31:0] store_merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Read-data source chosen by the latched bank number.
  always_comb begin
    bank_word = bankRData0;
    case (l_bank)
      2'd1:    bank_word = bankRData1;
      2'd2:    bank_word = bankRData2;
      default: bank_word = bankRData0;
    endcase
  end

  // Reject illegal accesses at acceptance.
  always_comb begin
    one_hot = (mEnab == 3'b001) || (mEnab == 3'b010) ||
              (mEnab == 3'b100);
    bad = iAddr || (mRead == mWrite) || (mSize == 2'b11) ||
          !one_hot ||
          ((mSize == 2'b01) && pAddr[0]) ||
          ((mSize == 2'b10) && (pAddr[1:0] != 2'b00));
  end

  // Access sequencer with registered strobes and responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ready    <= 1'b1;
      rData    <= '0;
      rValid   <= 1'b0;
      wDone    <= 1'b0;
      error    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      memRe    <= '0;
      memWe    <= '0;
      l_size   <= '0;
      l_sext   <= 1'b0;
      l_off    <= '0;
      l_bank   <= '0;
      l_enab   <= '0;
      l_wdata  <= '0;
    end else begin
      rValid <= 1'b0;
      wDone  <= 1'b0;
      error  <= 1'b0;
      memRe  <= '0;
      memWe  <= '0;
      unique case (state)
        S_IDLE: begin
          if (req && ready) begin
            ready   <= 1'b0;
            l_size  <= mSize;
            l_sext  <= mSignExt;
            l_off   <= pAddr[1:0];
            l_bank  <= mBank;
            l_enab  <= mEnab;
            l_wdata <= wData;
            if (bad) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              memAddr <= pAddr[PADDR_W-1:2];
              if (mWrite && (mSize == 2'b10)) begin
                memWe    <= mEnab;
                memWData <= wData;
                wDone    <= 1'b1;
                state    <= S_WR;
              end else begin
                memRe <= mEnab;
                state <= mWrite ? S_RMW_RD : S_RD;
              end
            end
          end
        end
        S_RD: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_RMW_RD: begin
          cnt   <= '0;
          state <= S_RMW_WAIT;
        end
        S_WAIT: begin
          if (cnt == CNT_LAST) begin
            rData  <= load_ext(bank_word, l_size, l_off, l_sext);
            rValid <= 1'b1;
            state  <= S_RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_RMW_WAIT: begin
          if (cnt == CNT_LAST) begin
            memWData <= store_merge(bank_word, l_wdata, l_size, l_off);
            memWe    <= l_enab;
            wDone    <= 1'b1;
            state    <= S_RMW_WR;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_ERR, S_WR, S_RESP, S_RMW_WR: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
